datamem_arbiter: RTL

Two-port arbiter and sequencer for the 16-entry x 8-bit data memory of the 16-bit microprocessor. It shares the single memory port (en, we, addr, din, dout) between the CPU load/store unit (port 0) and a debug/DMA requester (port 1). A registered grant FSM gives each requester one memory access per granted cycle and returns registered read data with a one-cycle valid pulse.

---
 rtl/datamem_pkg.sv | 20 ++
 rtl/datamem_arb_fsm.sv | 110 +++++++++++
 rtl/datamem_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/datamem_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package datamem_pkg;

  localparam int unsigned DEF_AW       = 4;
  localparam int unsigned DEF_DW       = 8;
  localparam int unsigned DEF_MAX_HOLD = 8;

  // hold counter width covers the full legal MAX_HOLD range (2..255)
  localparam int unsigned HOLD_W = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage

// File: rtl/datamem_arb_fsm.sv
// Grant FSM for the data-memory arbiter: owner state, hold counter and,
// with DATAMEM_ARB_RR_EN defined, the last-owner register used for
// round-robin. Without the macro, port 0 has fixed priority over port 1.
module datamem_arb_fsm
  import datamem_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_lock0,
  input  logic i_lock1,
  output logic o_gnt0,
  output logic o_gnt1
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

  arb_state_t        r_state;
  arb_state_t        w_next;
  arb_state_t        w_idle_both;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_keep0;
  logic              w_keep1;
  logic              w_pri0;

  // an owner keeps the port while it locks and the hold limit is not reached
  assign w_keep0 = i_req0 && i_lock0 && (r_hold_cnt < HOLD_LIM);
  assign w_keep1 = i_req1 && i_lock1 && (r_hold_cnt < HOLD_LIM);

`ifdef DATAMEM_ARB_RR_EN
  logic r_last_owner;

  // remember which port entered ownership most recently
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_owner <= PORT1;
    end else if (w_next != r_state) begin
      if (w_next == OWN0) begin
        r_last_owner <= PORT0;
      end else if (w_next == OWN1) begin
        r_last_owner <= PORT1;
      end
    end
  end

  assign w_idle_both = (r_last_owner == PORT0) ? OWN1 : OWN0;
  assign w_pri0      = 1'b0;
`else
  assign w_idle_both = OWN0;
  // fixed priority: an unlocked active port 0 is never displaced by port 1;
  // only the lock limit or dropping req0 hands the port over
  assign w_pri0      = i_req0 && !i_lock0;
`endif

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // hold counter: consecutive cycles in the same owner state, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if ((w_next != r_state) || (r_state == IDLE)) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt < HOLD_LIM) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // next-state selection from current requests and locks
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (i_req0 && i_req1) w_next = w_idle_both;
        else if (i_req0)      w_next = OWN0;
        else if (i_req1)      w_next = OWN1;
        else                  w_next = IDLE;
      end
      OWN0: begin
        if (w_keep0 || w_pri0) w_next = OWN0;
        else if (i_req1)       w_next = OWN1;
        else if (i_req0)       w_next = OWN0;
        else                   w_next = IDLE;
      end
      OWN1: begin
        if (w_keep1)     w_next = OWN1;
        else if (i_req0) w_next = OWN0;
        else if (i_req1) w_next = OWN1;
        else             w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // grants decode directly from the registered state
  always_comb begin
    o_gnt0 = (r_state == OWN0);
    o_gnt1 = (r_state == OWN1);
  end

endmodule

// File: rtl/datamem_arbiter.sv
// Two-port arbiter for the 16x8 data memory: CPU load/store (port 0) and
// debug/DMA (port 1). Grant FSM lives in datamem_arb_fsm; this level muxes
// the memory port and registers read data with a one-cycle valid pulse.
// Define DATAMEM_ARB_RR_EN for round-robin; default is fixed priority.
module datamem_arbiter
  import datamem_pkg::*;
#(
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW,
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          lock0,
  output logic          gnt0,
  output logic [DW-1:0] rdata0,
  output logic          rvalid0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          lock1,
  output logic          gnt1,
  output logic [DW-1:0] rdata1,
  output logic          rvalid1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_dout
);

  logic          w_acc0;
  logic          w_acc1;
  logic [DW-1:0] r_rdata0;
  logic [DW-1:0] r_rdata1;
  logic          r_rvalid0;
  logic          r_rvalid1;

  datamem_arb_fsm #(
    .MAX_HOLD (MAX_HOLD)
  ) u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_lock0 (lock0),
    .i_lock1 (lock1),
    .o_gnt0  (gnt0),
    .o_gnt1  (gnt1)
  );

  // an access happens only while the owner still requests
  assign w_acc0 = gnt0 && req0;
  assign w_acc1 = gnt1 && req1;

  // memory port mux: owner drives the bus, everything zero otherwise
  always_comb begin
    mem_en   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (w_acc0) begin
      mem_en   = 1'b1;
      mem_we   = we0;
      mem_addr = addr0;
      mem_din  = wdata0;
    end else if (w_acc1) begin
      mem_en   = 1'b1;
      mem_we   = we1;
      mem_addr = addr1;
      mem_din  = wdata1;
    end
  end

  // capture read data at the end of each read access; valid pulses next cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata0  <= '0;
      r_rdata1  <= '0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
    end else begin
      r_rvalid0 <= w_acc0 && !we0;
      r_rvalid1 <= w_acc1 && !we1;
      if (w_acc0 && !we0) r_rdata0 <= mem_dout;
      if (w_acc1 && !we1) r_rdata1 <= mem_dout;
    end
  end

  assign rdata0  = r_rdata0;
  assign rdata1  = r_rdata1;
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;

endmodule
